// File: rtl/ad9517_spi_master.sv
// AD9517 SPI master: serialises 24-bit write/read frames onto a mode-0, MSB-first 4-wire bus.
// Latency: busy for CS_SETUP + 48*CLK_DIV + CS_HOLD + CS_GAP cycles after the accepting cycle.
// Backpressure: commands are only sampled while busy is low; commands seen while busy are dropped.
module ad9517_spi_master #(
  parameter int MOSI_DATA_WIDTH = 24,
  parameter int MISO_DATA_WIDTH = 8,
  parameter int CLK_DIV         = 4,
  parameter int CS_SETUP        = 2,
  parameter int CS_HOLD         = 2,
  parameter int CS_GAP          = 4
) (
  input  logic                       clk,
  input  logic                       rst,
  input  logic                       i_spi_wr_cmd,
  input  logic                       i_spi_rd_cmd,
  input  logic [MOSI_DATA_WIDTH-1:0] i_spi_wr_data,
  output logic [MISO_DATA_WIDTH-1:0] o_spi_rd_data,
  output logic                       o_spi_rd_valid,
  output logic                       o_spi_busy,
  output logic                       o_spi_sclk,
  output logic                       o_spi_cs_n,
  output logic                       o_spi_mosi,
  input  logic                       i_spi_miso
);

  // Instruction bits sent ahead of the captured read byte.
  localparam int INSTR_W = MOSI_DATA_WIDTH - MISO_DATA_WIDTH;

  // One shared phase counter covers every timed state, so size it for the longest phase.
  localparam int MAX_AB  = (CLK_DIV > CS_SETUP) ? CLK_DIV : CS_SETUP;
  localparam int MAX_CD  = (CS_HOLD > CS_GAP) ? CS_HOLD : CS_GAP;
  localparam int CNT_MAX = (MAX_AB > MAX_CD) ? MAX_AB : MAX_CD;
  localparam int CNT_W   = (CNT_MAX > 1) ? $clog2(CNT_MAX) : 1;
  localparam int BIT_W   = (MOSI_DATA_WIDTH > 1) ? $clog2(MOSI_DATA_WIDTH) : 1;

  typedef enum logic [2:0] {
    IDLE,
    SETUP,
    SHIFT,
    HOLD,
    GAP
  } state_t;

  state_t                     state;
  logic [CNT_W-1:0]           cnt;
  logic [BIT_W-1:0]           bit_cnt;
  logic [MOSI_DATA_WIDTH-1:0] tx_shreg;
  logic [MISO_DATA_WIDTH-1:0] rx_shreg;
  logic                       is_rd;

  // MOSI is the top of the transmit shift register; it only moves on SCLK falls and
  // drains to zero, which gives the zero-fill during read capture and in HOLD/GAP.
  assign o_spi_mosi = tx_shreg[MOSI_DATA_WIDTH-1];
  assign o_spi_busy = (state != IDLE);

  // Transaction sequencer: command accept, SCLK generation, shifting and CS framing.
  always_ff @(posedge clk) begin
    if (rst) begin
      state          <= IDLE;
      cnt            <= '0;
      bit_cnt        <= '0;
      tx_shreg       <= '0;
      rx_shreg       <= '0;
      is_rd          <= 1'b0;
      o_spi_rd_data  <= '0;
      o_spi_rd_valid <= 1'b0;
      o_spi_sclk     <= 1'b0;
      o_spi_cs_n     <= 1'b1;
    end else begin
      o_spi_rd_valid <= 1'b0;
      case (state)
        IDLE: begin
          o_spi_sclk <= 1'b0;
          o_spi_cs_n <= 1'b1;
          cnt        <= '0;
          bit_cnt    <= '0;
          // Write wins when both commands arrive together.
          if (i_spi_wr_cmd) begin
            tx_shreg   <= i_spi_wr_data;
            is_rd      <= 1'b0;
            o_spi_cs_n <= 1'b0;
            state      <= SETUP;
          end else if (i_spi_rd_cmd) begin
            tx_shreg   <= {i_spi_wr_data[INSTR_W-1:0], {MISO_DATA_WIDTH{1'b0}}};
            is_rd      <= 1'b1;
            o_spi_cs_n <= 1'b0;
            state      <= SETUP;
          end
        end

        SETUP: begin
          if (cnt == CNT_W'(CS_SETUP - 1)) begin
            cnt   <= '0;
            state <= SHIFT;
          end else begin
            cnt <= cnt + CNT_W'(1);
          end
        end

        SHIFT: begin
          if (cnt == CNT_W'(CLK_DIV - 1)) begin
            cnt <= '0;
            if (!o_spi_sclk) begin
              // Rising edge: device data has been stable since the previous fall.
              o_spi_sclk <= 1'b1;
              rx_shreg   <= {rx_shreg[MISO_DATA_WIDTH-2:0], i_spi_miso};
            end else begin
              // Falling edge: advance MOSI to the next bit.
              o_spi_sclk <= 1'b0;
              tx_shreg   <= {tx_shreg[MOSI_DATA_WIDTH-2:0], 1'b0};
              if (bit_cnt == BIT_W'(MOSI_DATA_WIDTH - 1)) begin
                bit_cnt <= '0;
                state   <= HOLD;
                if (is_rd) begin
                  o_spi_rd_data  <= rx_shreg;
                  o_spi_rd_valid <= 1'b1;
                end
              end else begin
                bit_cnt <= bit_cnt + BIT_W'(1);
              end
            end
          end else begin
            cnt <= cnt + CNT_W'(1);
          end
        end

        HOLD: begin
          if (cnt == CNT_W'(CS_HOLD - 1)) begin
            cnt        <= '0;
            o_spi_cs_n <= 1'b1;
            state      <= GAP;
          end else begin
            cnt <= cnt + CNT_W'(1);
          end
        end

        GAP: begin
          if (cnt == CNT_W'(CS_GAP - 1)) begin
            cnt   <= '0;
            state <= IDLE;
          end else begin
            cnt <= cnt + CNT_W'(1);
          end
        end

        default: begin
          state      <= IDLE;
          o_spi_sclk <= 1'b0;
          o_spi_cs_n <= 1'b1;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_ad9517_spi_master.sv
// Bench for ad9517_spi_master: bus-level monitor plus MISO device model, randomized frames.
// Expectations come from the frame rules: 24 rises, MSB first, fixed busy window of 200 cycles.
// Every transaction is bounded by a cycle budget so the run always reaches its summary.
module tb_ad9517_spi_master;

  localparam int BUSY_CYC = 2 + 48 * 4 + 2 + 4;
  localparam int GAP_CYC  = 4;

  logic        clk = 1'b0;
  logic        rst;
  logic        wr_cmd;
  logic        rd_cmd;
  logic [23:0] wr_data;
  logic [7:0]  rd_data;
  logic        rd_valid;
  logic        busy;
  logic        sclk;
  logic        cs_n;
  logic        mosi;
  logic        miso;

  int          n_chk  = 0;
  int          n_pass = 0;
  logic [7:0]  model_rd = 8'h00;

  ad9517_spi_master dut (
    .clk            (clk),
    .rst            (rst),
    .i_spi_wr_cmd   (wr_cmd),
    .i_spi_rd_cmd   (rd_cmd),
    .i_spi_wr_data  (wr_data),
    .o_spi_rd_data  (rd_data),
    .o_spi_rd_valid (rd_valid),
    .o_spi_busy     (busy),
    .o_spi_sclk     (sclk),
    .o_spi_cs_n     (cs_n),
    .o_spi_mosi     (mosi),
    .i_spi_miso     (miso)
  );

  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_chk++;
    if (got !== exp)
      $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
    else
      n_pass++;
  endtask

  // Issue one command at the current negedge and observe the whole frame.
  // poke_cyc > 0 pulses an extra wr_cmd at that busy cycle; abort_cyc > 0 asserts reset there.
  task automatic do_txn(input logic wr, input logic rd, input logic [23:0] data,
                        input logic [7:0] dev_byte, input int poke_cyc, input int abort_cyc,
                        input string tag);
    int         busy_n = 0, rises = 0, cs_fall = 0, cs_viol = 0, vld_n = 0, gap_n = 0;
    logic       prev_sclk = 1'b0, prev_cs = 1'b1, done = 1'b0, is_wr;
    logic [23:0] mo = '0, exp_mo;
    logic [7:0]  vld_dat = '0;
    int          idx;

    is_wr  = wr;
    exp_mo = is_wr ? data : {data[15:0], 8'h00};
    wr_cmd  = wr;
    rd_cmd  = rd;
    wr_data = data;
    miso    = 1'b0;
    @(posedge clk);
    @(negedge clk);
    wr_cmd  = 1'b0;
    rd_cmd  = 1'b0;
    wr_data = 24'($urandom);

    for (int cyc = 1; cyc <= 400; cyc++) begin
      if (abort_cyc > 0 && cyc == abort_cyc) begin
        rst = 1'b1;
        @(negedge clk);
        rst = 1'b0;
        chk({tag, "_rst_cs_n"}, 32'(cs_n), 32'd1);
        chk({tag, "_rst_sclk"}, 32'(sclk), 32'd0);
        chk({tag, "_rst_busy"}, 32'(busy), 32'd0);
        chk({tag, "_rst_mosi"}, 32'(mosi), 32'd0);
        chk({tag, "_rst_rd_data"}, 32'(rd_data), 32'd0);
        chk({tag, "_rst_rd_valid"}, 32'(rd_valid), 32'd0);
        model_rd = 8'h00;
        miso = 1'b0;
        return;
      end
      if (!busy) begin
        done = 1'b1;
        break;
      end
      wr_cmd = (poke_cyc > 0 && cyc == poke_cyc);
      busy_n++;
      if (!cs_n && prev_cs) cs_fall++;
      if (cs_n) gap_n++;
      if (sclk && !prev_sclk) begin
        rises++;
        mo = {mo[22:0], mosi};
        if (cs_n) cs_viol++;
      end
      if (rd_valid) begin
        vld_n++;
        vld_dat = rd_data;
      end
      // Device model: drive capture bit k while k rises have been seen.
      idx  = 23 - rises;
      miso = (rises >= 16 && rises < 24) ? dev_byte[idx[2:0]] : 1'b0;
      prev_sclk = sclk;
      prev_cs   = cs_n;
      @(negedge clk);
    end
    wr_cmd = 1'b0;
    miso   = 1'b0;

    chk({tag, "_done"}, 32'(done), 32'd1);
    chk({tag, "_busy_cycles"}, busy_n, BUSY_CYC);
    chk({tag, "_rises"}, rises, 24);
    chk({tag, "_mosi"}, 32'(mo), 32'(exp_mo));
    chk({tag, "_cs_low"}, cs_viol, 0);
    chk({tag, "_frames"}, cs_fall, 1);
    chk({tag, "_gap"}, gap_n, GAP_CYC);
    chk({tag, "_vld_n"}, vld_n, is_wr ? 0 : 1);
    if (!is_wr) begin
      model_rd = dev_byte;
      chk({tag, "_vld_dat"}, 32'(vld_dat), 32'(dev_byte));
    end
    chk({tag, "_rd_data"}, 32'(rd_data), 32'(model_rd));
    chk({tag, "_idle_cs"}, 32'({cs_n, sclk}), 32'b10);
  endtask

  initial begin
    rst     = 1'b1;
    wr_cmd  = 1'b0;
    rd_cmd  = 1'b0;
    wr_data = '0;
    miso    = 1'b0;
    repeat (3) @(posedge clk);
    @(negedge clk);
    chk("reset_busy", 32'(busy), 32'd0);
    chk("reset_cs_n", 32'(cs_n), 32'd1);
    chk("reset_sclk", 32'(sclk), 32'd0);
    chk("reset_mosi", 32'(mosi), 32'd0);
    chk("reset_rd_data", 32'(rd_data), 32'd0);
    chk("reset_rd_valid", 32'(rd_valid), 32'd0);
    rst = 1'b0;
    @(negedge clk);

    do_txn(1'b1, 1'b0, 24'h000018, 8'h00, 0, 0, "wr18");
    do_txn(1'b0, 1'b1, 24'h008003, 8'h53, 0, 0, "rd8003");
    // Issued in the first idle cycle after the previous frame.
    do_txn(1'b1, 1'b0, 24'h5A5A5A, 8'h00, 0, 0, "b2b");
    do_txn(1'b1, 1'b0, 24'h123456, 8'h00, 50, 0, "busy_cmd");
    repeat (3) @(negedge clk);
    chk("busy_cmd_ignored", 32'(busy), 32'd0);
    do_txn(1'b1, 1'b1, 24'h80ABCD, 8'hFF, 0, 0, "both");

    for (int i = 0; i < 6; i++) begin
      logic [23:0] d;
      logic [7:0]  b;
      logic        w;
      d = 24'($urandom);
      b = 8'($urandom);
      w = 1'($urandom);
      do_txn(w, ~w, d, b, 0, 0, $sformatf("rnd%0d", i));
    end

    do_txn(1'b0, 1'b1, 24'h00C3A5, 8'hA5, 0, 0, "rd_pre_abort");
    do_txn(1'b0, 1'b1, 24'h000123, 8'h3C, 0, 100, "abort");
    @(negedge clk);
    do_txn(1'b0, 1'b1, 24'h008003, 8'h96, 0, 0, "rd_post_abort");

    $display("%0d/%0d checks passed", n_pass, n_chk);
    $finish;
  end

endmodule
